// File: rtl/fetch_unit.sv
// fetch_unit: instruction-byte fetch stage in front of the control unit.
//   Owns the program counter and drives a synchronous (1-cycle latency)
//   program ROM. A small prefetch FIFO keeps the next byte ready on rom_data
//   so that the control unit can consume one byte per cycle.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   rom_en     out  ROM read strobe (data returns next cycle)
//   rom_addr   out  ROM read address
//   rom_rdata  in   ROM read data, valid the cycle after rom_en
//   pc_inc     in   pop strobe from the control unit
//   jump_en    in   redirect request (single-cycle pulse)
//   jump_addr  in   redirect target
//   rom_data   out  FIFO head byte, 0 when empty
//   rom_valid  out  FIFO non-empty
//   pc         out  address of head byte (next expected address when empty)
//   underflow  out  sticky flag: pc_inc seen while rom_valid=0
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic              pc_inc,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic              rom_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  logic [DATA_W-1:0] fifo_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              underflow_q, underflow_d;

  logic              pop;
  logic              push;
  logic [CNT_W:0]    occupancy;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rom_valid = (count_q != '0);
  // A jump overrides any pop and kills the response landing this cycle.
  assign pop       = pc_inc & rom_valid & ~jump_en;
  assign push      = inflight_q & ~jump_en;

  // Slots committed after this cycle's pop; a pop frees a slot for an issue
  // in the same cycle, which is what sustains one byte per cycle.
  assign occupancy = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(inflight_q)
                   - (CNT_W + 1)'(pop);

  assign rom_en   = ~rst & (jump_en | (occupancy < (CNT_W + 1)'(DEPTH)));
  // Jump target is bypassed straight to the ROM so it is fetched in the jump cycle.
  assign rom_addr = rst ? RST_PC : (jump_en ? jump_addr : fetch_addr_q);

  assign rom_data  = rom_valid ? fifo_mem[rd_ptr_q] : '0;
  assign pc        = pc_q;
  assign underflow = underflow_q;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    inflight_d   = inflight_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    underflow_d  = underflow_q;
    if (jump_en) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      inflight_d   = 1'b1;
      fetch_addr_d = jump_addr + ADDR_W'(1);
      pc_d         = jump_addr;
    end else begin
      inflight_d   = rom_en;
      fetch_addr_d = fetch_addr_q + ADDR_W'(rom_en);
      if (push) wr_ptr_d = ptr_next(wr_ptr_q);
      if (pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
        pc_d     = pc_q + ADDR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (pc_inc && !rom_valid) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      fetch_addr_q <= RST_PC;
      pc_q         <= RST_PC;
      underflow_q  <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rom_rdata;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
//   The driver keeps an architectural model (program counter, ROM image,
//   cycles since the last redirect, sticky underflow) and pushes the expected
//   outputs of every cycle into a queue; a monitor pops and compares them
//   mid-cycle.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_rdata = 8'h00;
  logic       pc_inc = 1'b0;
  logic       jump_en = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic [7:0] rom_data;
  logic       rom_valid;
  logic [7:0] pc;
  logic       underflow;

  fetch_unit #(.ADDR_W(8), .DATA_W(8), .DEPTH(2), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_rdata(rom_rdata), .pc_inc(pc_inc), .jump_en(jump_en),
    .jump_addr(jump_addr), .rom_data(rom_data), .rom_valid(rom_valid),
    .pc(pc), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM.
  logic [7:0] rom [256];
  always @(posedge clk) if (rom_en) rom_rdata <= rom[rom_addr];

  typedef struct {
    bit       valid;
    bit       pop;
    bit [7:0] pc;
    bit [7:0] data;
    bit       uf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_on = 0;

  // Architectural model
  int       age;
  bit [7:0] model_pc;
  bit       exp_uf;
  bit       last_en;
  bit [7:0] last_addr;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rom_valid", int'(rom_valid), int'(e.valid));
        check("pc", int'(pc), int'(e.pc));
        check("rom_data", int'(rom_data), int'(e.data));
        check("underflow", int'(underflow), int'(e.uf));
        if (e.pop)
          $display("consume pc=%02h data=%02h (dut pc=%02h data=%02h)", e.pc, e.data, pc, rom_data);
      end
    end
  end

  // One cycle of stimulus. Entered at posedge+1, returns at next posedge+1.
  task automatic step(input bit inc, input bit jmp, input bit [7:0] ja);
    exp_t e;
    if (age < 3) age++;
    e.valid = (age >= 2);
    e.pc    = model_pc;
    e.data  = e.valid ? rom[model_pc] : 8'h00;
    e.uf    = exp_uf;
    e.pop   = inc && e.valid && !jmp;
    exp_q.push_back(e);
    pc_inc = inc; jump_en = jmp; jump_addr = ja;
    if (jmp) begin
      model_pc = ja;
      age = 0;
    end else if (inc && e.valid) begin
      model_pc = model_pc + 8'd1;
    end else if (inc) begin
      exp_uf = 1'b1;
    end
    #2;
    last_en = rom_en;
    last_addr = rom_addr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    mon_on = 0;
    exp_q.delete();
    pc_inc = 0; jump_en = 0; jump_addr = 8'h00;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_en", int'(rom_en), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_rom_valid", int'(rom_valid), 0);
    check("rst_rom_data", int'(rom_data), 0);
    check("rst_pc", int'(pc), 0);
    check("rst_underflow", int'(underflow), 0);
    rst = 0;
    age = -1; model_pc = 8'h00; exp_uf = 0;
    mon_on = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int issues;
    for (int i = 0; i < 256; i++) rom[i] = 8'(i + 16);
    @(posedge clk); #1;

    // Reset, no consumption: two issues only, first byte at cycle 2.
    do_reset();
    issues = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 8'h00);
      if (last_en) issues++;
    end
    check("issue_count_full", issues, 2);
    $display("reset fill: %0d issues", issues);

    // Streaming with no bubbles.
    for (int c = 0; c < 8; c++) step(1, 0, 8'h00);

    // Fill, then jump while the FIFO is full.
    for (int c = 0; c < 3; c++) step(0, 0, 8'h00);
    step(0, 1, 8'h40);
    check("jump_rom_en", int'(last_en), 1);
    check("jump_rom_addr", int'(last_addr), 8'h40);
    $display("jump to 40: rom_en=%0d rom_addr=%02h", last_en, last_addr);
    for (int c = 0; c < 5; c++) step(1, 0, 8'h00);

    // Jump with pc_inc in the same cycle, then stream across the wrap.
    step(1, 1, 8'hFE);
    for (int c = 0; c < 7; c++) step(1, 0, 8'h00);

    // Underflow right after reset.
    do_reset();
    step(1, 0, 8'h00);
    for (int c = 0; c < 5; c++) step(1, 0, 8'h00);

    // Asynchronous reset mid-stream: outputs return immediately.
    step(1, 0, 8'h00);
    mon_on = 0;
    exp_q.delete();
    #1;
    rst = 1;
    #1;
    check("arst_rom_en", int'(rom_en), 0);
    check("arst_rom_addr", int'(rom_addr), 0);
    check("arst_rom_valid", int'(rom_valid), 0);
    check("arst_rom_data", int'(rom_data), 0);
    check("arst_pc", int'(pc), 0);
    check("arst_underflow", int'(underflow), 0);
    $display("async reset: outputs rom_en=%0d valid=%0d pc=%02h uf=%0d", rom_en, rom_valid, pc, underflow);
    @(posedge clk); #1;

    // Randomized phase on a random ROM image.
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bit inc, jmp;
      inc = ($urandom_range(0, 3) != 0);
      jmp = ($urandom_range(0, 15) == 0);
      step(inc, jmp, 8'($urandom_range(0, 255)));
    end
    step(0, 0, 8'h00);

    mon_on = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
